// File: rtl/int_exec_pipe_unit.sv
// int_exec_pipe_unit: pipelined integer ALU/branch unit between the issue queue and the CDB.
// Entry and bus packing, MSB to LSB: {data[XLEN], tag[TAG_W], valid, branch, taken}.
module int_exec_pipe_unit #(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 6,
    parameter int PIPE_DEPTH     = 2,
    parameter int OUT_FIFO_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_int,
    output logic                    int_ready,
    input  logic [6:0]              Opcode,
    input  logic [2:0]              Funct3,
    input  logic [6:0]              Funct7,
    input  logic [XLEN-1:0]         RS1,
    input  logic [XLEN-1:0]         RS2,
    input  logic [TAG_W-1:0]        RD_Tag,
    input  logic                    flush,
    output logic                    cdb_req,
    input  logic                    cdb_grant,
    output logic [XLEN+TAG_W+2:0]   cdb_int_unit
);
    localparam int EW = XLEN + TAG_W + 3;
    localparam int PW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic                   is_branch;
    logic                   is_alt;
    logic                   taken;
    logic                   accept;
    logic                   pop;
    logic                   fifo_push;
    logic [SW-1:0]          shamt;
    logic [XLEN-1:0]        alu_res;
    logic signed [XLEN-1:0] sra_res;
    logic [EW-1:0]          new_entry;
    logic [EW-1:0]          fifo_din;
    logic [EW-1:0]          mem_q [OUT_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          occ_q;
    logic [CW-1:0]          occ_d;

    assign is_branch = (Opcode == OP_B);
    assign is_alt    = (Funct7 == 7'b0100000);
    assign shamt     = RS2[SW-1:0];
    assign sra_res   = $signed(RS1) >>> shamt;

    // occ is a credit count of everything accepted but not yet granted, so
    // int_ready never depends combinationally on cdb_grant.
    assign int_ready = (occ_q < CW'(OUT_FIFO_DEPTH));
    assign accept    = issue_int && int_ready && !flush;
    assign cdb_req   = (cnt_q != '0) && !flush;
    assign pop       = cdb_req && cdb_grant;

    // ALU: RV32I register/immediate operations selected by funct3; SUB only for R-type.
    always_comb begin
        alu_res = RS1 + RS2;
        case (Funct3)
            3'b000: alu_res = (Opcode == OP_R && is_alt) ? (RS1 - RS2) : (RS1 + RS2);
            3'b001: alu_res = RS1 << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(RS1) < $signed(RS2))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (RS1 < RS2)};
            3'b100: alu_res = RS1 ^ RS2;
            3'b101: alu_res = is_alt ? sra_res : (RS1 >> shamt);
            3'b110: alu_res = RS1 | RS2;
            3'b111: alu_res = RS1 & RS2;
            default: alu_res = RS1 + RS2;
        endcase
    end

    // Branch condition comparators; the two reserved funct3 codes resolve not-taken.
    always_comb begin
        taken = 1'b0;
        case (Funct3)
            3'b000: taken = (RS1 == RS2);
            3'b001: taken = (RS1 != RS2);
            3'b100: taken = ($signed(RS1) < $signed(RS2));
            3'b101: taken = ($signed(RS1) >= $signed(RS2));
            3'b110: taken = (RS1 < RS2);
            3'b111: taken = (RS1 >= RS2);
            default: taken = 1'b0;
        endcase
    end

    assign new_entry = is_branch ? {{XLEN{1'b0}}, {TAG_W{1'b0}}, 1'b0, 1'b1, taken}
                                 : {alu_res, RD_Tag, 1'b1, 1'b0, 1'b0};

    generate
        if (PIPE_DEPTH == 1) begin : g_no_stage
            assign fifo_push = accept;
            assign fifo_din  = new_entry;
        end else begin : g_stage
            localparam int NS = PIPE_DEPTH - 1;
            logic [NS-1:0] vld_q;
            logic [EW-1:0] ent_q [NS];

            // Fixed-latency shift pipeline; only the valid bits need clearing.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    for (int i = 1; i < NS; i++) vld_q[i] <= vld_q[i-1];
                end
                ent_q[0] <= new_entry;
                for (int i = 1; i < NS; i++) ent_q[i] <= ent_q[i-1];
            end

            assign fifo_push = vld_q[NS-1];
            assign fifo_din  = ent_q[NS-1];
        end
    endgenerate

    // Next-state for FIFO fill level and credit count.
    always_comb begin
        cnt_d = cnt_q;
        occ_d = occ_q;
        if (fifo_push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!fifo_push && pop) cnt_d = cnt_q - 1'b1;
        if (accept && !pop)         occ_d = occ_q + 1'b1;
        else if (!accept && pop)    occ_d = occ_q - 1'b1;
    end

    // Output FIFO storage, pointers and counters; flush and reset both empty it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
        end else begin
            if (fifo_push) begin
                mem_q[wr_ptr_q] <= fifo_din;
                wr_ptr_q <= (wr_ptr_q == PW'(OUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(OUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
            occ_q <= occ_d;
        end
    end

    assign cdb_int_unit = pop ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_int_exec_pipe_unit.sv
// Self-checking bench for int_exec_pipe_unit with a queue-based reference model.
module tb_int_exec_pipe_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int PD    = 2;
    localparam int DEPTH = 3;
    localparam int EW    = XLEN + TAG_W + 3;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic              clk = 1'b0;
    logic              rst, issue_int, flush, cdb_grant;
    logic [6:0]        Opcode, Funct7;
    logic [2:0]        Funct3;
    logic [XLEN-1:0]   RS1, RS2;
    logic [TAG_W-1:0]  RD_Tag;
    logic              int_ready, cdb_req;
    logic [EW-1:0]     cdb_int_unit;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_illegal = 0;

    typedef struct {
        logic [EW-1:0] ent;
        int            rdy;
    } pend_t;
    pend_t mq[$];

    logic          er, eq;
    logic [EW-1:0] eb;

    int_exec_pipe_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .PIPE_DEPTH(PD), .OUT_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .issue_int(issue_int), .int_ready(int_ready),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .RS1(RS1), .RS2(RS2),
        .RD_Tag(RD_Tag), .flush(flush), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_int_unit(cdb_int_unit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ISA-level result of one micro-op, packed as {data, tag, valid, branch, taken}.
    function automatic logic [EW-1:0] ref_entry(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                                logic [31:0] a, logic [31:0] b, logic [5:0] tag);
        logic [31:0] r;
        logic        t;
        int          sh;
        logic        alt;
        alt = (f7 == 7'h20);
        sh  = int'(b[4:0]);
        if (op == OP_B) begin
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = ($signed(a) >= $signed(b));
                3'd6: t = (a < b);
                3'd7: t = (a >= b);
                default: t = 1'b0;
            endcase
            return {32'd0, 6'd0, 1'b0, 1'b1, t};
        end
        case (f3)
            3'd0: r = (op == OP_R && alt) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {r, tag, 1'b1, 1'b0, 1'b0};
    endfunction

    // Expected outputs for the current cycle from the model state and current inputs.
    task automatic model_expect(output logic e_ready, output logic e_req, output logic [EW-1:0] e_bus);
        e_ready = (mq.size() < DEPTH);
        e_req   = (mq.size() > 0) && (mq[0].rdy <= cyc) && !flush;
        e_bus   = (e_req && cdb_grant) ? mq[0].ent : '0;
    endtask

    // Update the model with the current inputs and move to the next cycle.
    task automatic advance();
        logic  acc, pop;
        pend_t p;
        acc = issue_int && (mq.size() < DEPTH) && !flush && !rst;
        pop = (mq.size() > 0) && (mq[0].rdy <= cyc) && !flush && cdb_grant && !rst;
        if (issue_int && !acc && !flush && !rst) n_illegal++;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                p.ent = ref_entry(Opcode, Funct3, Funct7, RS1, RS2, RD_Tag);
                p.rdy = cyc + PD;
                mq.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                          logic [31:0] a, logic [31:0] b, logic [5:0] tag);
        Opcode = op; Funct3 = f3; Funct7 = f7; RS1 = a; RS2 = b; RD_Tag = tag;
    endtask

    task automatic rand_op();
        int k;
        k = $urandom_range(2, 0);
        Opcode = (k == 0) ? OP_R : (k == 1) ? OP_I : OP_B;
        Funct3 = 3'($urandom);
        Funct7 = ($urandom_range(1, 0) == 1) ? 7'h20 : 7'h00;
        RS1    = $urandom;
        RS2    = ($urandom_range(3, 0) == 0) ? RS1 : $urandom;
        if ($urandom_range(3, 0) == 0) RS2 = 32'($urandom_range(40, 0));
        RD_Tag = 6'($urandom);
    endtask

    task automatic go_idle();
        issue_int = 1'b0; flush = 1'b1; cdb_grant = 1'b0; rst = 1'b0;
        advance();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_int = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
        set_op(OP_R, 3'd0, 7'd0, 32'd0, 32'd0, 6'd0);
        advance();
        advance();
        rst = 1'b0; cdb_grant = 1'b1;
        #1;
        checks++;
        if (int_ready !== 1'b1 || cdb_req !== 1'b0 || cdb_int_unit !== '0) begin
            failures++;
            $display("FAIL reset_state ready=%b req=%b bus=%h required 1 0 0", int_ready, cdb_req, cdb_int_unit);
        end
        advance();
    endtask

    task automatic test_single_add();
        go_idle();
        cdb_grant = 1'b1; issue_int = 1'b1;
        set_op(OP_R, 3'd0, 7'd0, 32'd5, 32'd7, 6'h12);
        #1;
        model_expect(er, eq, eb); checks++;
        if (int_ready !== er || cdb_req !== eq || cdb_int_unit !== eb) begin
            failures++;
            $display("FAIL add_model cyc=%0d ready=%b/%b req=%b/%b bus=%h/%h", cyc, int_ready, er, cdb_req, eq, cdb_int_unit, eb);
        end
        advance();
        issue_int = 1'b0;
        #1;
        checks++;
        if (cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL add_early_req req=%b required 0", cdb_req);
        end
        advance();
        #1;
        checks++;
        if (cdb_req !== 1'b1 || cdb_int_unit !== {32'd12, 6'h12, 3'b100}) begin
            failures++;
            $display("FAIL add_result req=%b bus=%h required 1 %h", cdb_req, cdb_int_unit, {32'd12, 6'h12, 3'b100});
        end
        advance();
    endtask

    task automatic test_branch_sweep();
        logic [7:0] tk;
        logic [2:0] f;
        tk = 8'b1001_0010;
        go_idle();
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f = 3'(i);
            issue_int = 1'b1;
            set_op(OP_B, f, 7'd0, 32'hFFFF_FFFF, 32'd1, 6'h2A);
            advance();
            issue_int = 1'b0;
            advance();
            #1;
            checks++;
            if (cdb_req !== 1'b1 || cdb_int_unit !== {32'd0, 6'd0, 1'b0, 1'b1, tk[f]}) begin
                failures++;
                $display("FAIL branch_f3_%0d req=%b bus=%h required taken=%b", i, cdb_req, cdb_int_unit, tk[f]);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int got[$];
        go_idle();
        cdb_grant = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue_int = 1'b1;
            set_op(OP_I, 3'd0, 7'd0, 32'(i), 32'd0, 6'(i + 1));
            #1;
            model_expect(er, eq, eb); checks++;
            if (int_ready !== er || cdb_req !== eq || cdb_int_unit !== eb) begin
                failures++;
                $display("FAIL bp_model cyc=%0d ready=%b/%b req=%b/%b bus=%h/%h", cyc, int_ready, er, cdb_req, eq, cdb_int_unit, eb);
            end
            checks++;
            if (int_ready !== (i < DEPTH)) begin
                failures++;
                $display("FAIL bp_ready step=%0d ready=%b required %b", i, int_ready, (i < DEPTH));
            end
            advance();
        end
        issue_int = 1'b0; cdb_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            model_expect(er, eq, eb); checks++;
            if (int_ready !== er || cdb_req !== eq || cdb_int_unit !== eb) begin
                failures++;
                $display("FAIL bp_drain cyc=%0d ready=%b/%b req=%b/%b bus=%h/%h", cyc, int_ready, er, cdb_req, eq, cdb_int_unit, eb);
            end
            if (cdb_req === 1'b1) got.push_back(int'(cdb_int_unit[TAG_W+2:3]));
            advance();
        end
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
            failures++;
            $display("FAIL bp_order count=%0d required 3 tags 1,2,3", got.size());
        end
    endtask

    task automatic test_streaming();
        int tags[$];
        int first, last;
        first = -1; last = -1;
        go_idle();
        cdb_grant = 1'b1;
        for (int i = 0; i < 24; i++) begin
            issue_int = (i < 20);
            rand_op();
            RD_Tag = 6'(i);
            if (Opcode == OP_B) Opcode = OP_I;
            #1;
            model_expect(er, eq, eb); checks++;
            if (int_ready !== er || cdb_req !== eq || cdb_int_unit !== eb) begin
                failures++;
                $display("FAIL stream_model cyc=%0d ready=%b/%b req=%b/%b bus=%h/%h", cyc, int_ready, er, cdb_req, eq, cdb_int_unit, eb);
            end
            if (i < 20 && int_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready step=%0d ready=%b required 1", i, int_ready);
            end
            if (cdb_req === 1'b1) begin
                tags.push_back(int'(cdb_int_unit[TAG_W+2:3]));
                if (first < 0) first = i;
                last = i;
            end
            advance();
        end
        checks++;
        if (tags.size() != 20 || last - first != 19) begin
            failures++;
            $display("FAIL stream_count count=%0d span=%0d required 20 and 19", tags.size(), last - first);
        end
        for (int i = 0; i < tags.size(); i++) begin
            checks++;
            if (tags[i] != i) begin
                failures++;
                $display("FAIL stream_order idx=%0d tag=%0d required %0d", i, tags[i], i);
            end
        end
    endtask

    task automatic test_flush();
        go_idle();
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_int = 1'b1;
            set_op(OP_R, 3'd4, 7'd0, 32'(i * 3), 32'h55, 6'(i + 9));
            advance();
        end
        flush = 1'b1; issue_int = 1'b1; cdb_grant = 1'b1;
        #1;
        checks++;
        if (cdb_req !== 1'b0 || cdb_int_unit !== '0) begin
            failures++;
            $display("FAIL flush_cycle req=%b bus=%h required 0 0", cdb_req, cdb_int_unit);
        end
        advance();
        flush = 1'b0; issue_int = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            model_expect(er, eq, eb); checks++;
            if (int_ready !== 1'b1 || cdb_req !== 1'b0 || cdb_int_unit !== '0 || eq !== 1'b0) begin
                failures++;
                $display("FAIL flush_after step=%0d ready=%b req=%b bus=%h required 1 0 0", i, int_ready, cdb_req, cdb_int_unit);
            end
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        go_idle();
        cdb_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue_int = 1'b1;
            rand_op();
            advance();
        end
        rst = 1'b1;
        advance();
        rst = 1'b0; issue_int = 1'b0;
        #1;
        checks++;
        if (int_ready !== 1'b1 || cdb_req !== 1'b0 || cdb_int_unit !== '0) begin
            failures++;
            $display("FAIL rst_mid ready=%b req=%b bus=%h required 1 0 0", int_ready, cdb_req, cdb_int_unit);
        end
        issue_int = 1'b1;
        set_op(OP_R, 3'd0, 7'd0, 32'd100, 32'd23, 6'd5);
        advance();
        issue_int = 1'b0;
        #1;
        checks++;
        if (cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_lat_early req=%b required 0", cdb_req);
        end
        advance();
        #1;
        checks++;
        if (cdb_req !== 1'b1 || cdb_int_unit !== {32'd123, 6'd5, 3'b100}) begin
            failures++;
            $display("FAIL rst_lat_result req=%b bus=%h required 1 %h", cdb_req, cdb_int_unit, {32'd123, 6'd5, 3'b100});
        end
        advance();
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 500; i++) begin
            issue_int = ($urandom_range(9, 0) < 7);
            cdb_grant = ($urandom_range(9, 0) < 6);
            flush     = ($urandom_range(39, 0) == 0);
            rst       = ($urandom_range(99, 0) == 0);
            rand_op();
            #1;
            if (!rst) begin
                model_expect(er, eq, eb); checks++;
                if (int_ready !== er || cdb_req !== eq || cdb_int_unit !== eb) begin
                    failures++;
                    $display("FAIL rand_model cyc=%0d ready=%b/%b req=%b/%b bus=%h/%h", cyc, int_ready, er, cdb_req, eq, cdb_int_unit, eb);
                end
            end
            advance();
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_int = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
        set_op(OP_R, 3'd0, 7'd0, 32'd0, 32'd0, 6'd0);
        #1;
        test_reset();
        test_single_add();
        test_branch_sweep();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("note: %0d issue attempts while int_ready=0 were protocol errors and were ignored", n_illegal);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
